xm_stage: RTL

- Execute-to-memory boundary register that sits directly downstream of the ALU.
- Captures the ALU result and flags, and resolves bne/blt branches from notEqual/lessThan.
- On an ALU exception, redirects the writeback to the rstatus register.
- Runs a small FSM that stalls upstream while a multiply waits for mult_ready, with a timeout guard.

---
 rtl/xm_stage_pkg.sv | 18 +
 rtl/mul_wait_ctrl.sv | 69 ++++++
 rtl/xm_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/xm_stage_pkg.sv
// Shared definitions for the execute-to-memory boundary and the ALU overflow logic.
package xm_stage_pkg;

    localparam logic [4:0] RSTATUS_REG = 5'd30;

    // rstatus codes written on an ALU exception
    localparam logic [31:0] RS_NONE = 32'd0;
    localparam logic [31:0] RS_ADD  = 32'd1;
    localparam logic [31:0] RS_ADDI = 32'd2;
    localparam logic [31:0] RS_SUB  = 32'd3;
    localparam logic [31:0] RS_MUL  = 32'd4;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mul_wait_ctrl.sv
// Multiply wait FSM: holds upstream while the multiplier is busy and aborts the op
// if mult_ready never arrives within MUL_TIMEOUT cycles.
module mul_wait_ctrl
    import xm_stage_pkg::*;
#(
    parameter int MUL_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    input  logic in_is_mul,
    input  logic mult_ready,
    output logic stall,
    output logic capture,
    output logic abort,
    output logic mul_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MUL_TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             wait_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    always_comb begin
        wait_done = (cnt >= CNT_MAX);
        stall     = !reset &&
                    (((state == IDLE) && in_valid && in_is_mul) ||
                     ((state == MUL_WAIT) && !mult_ready && !wait_done));
        capture   = ((state == IDLE) && in_valid && !in_is_mul) ||
                    ((state == MUL_WAIT) && mult_ready);
        abort     = (state == MUL_WAIT) && !mult_ready && wait_done;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            mul_timeout <= 1'b0;
        end else begin
            mul_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_is_mul) begin
                        state <= MUL_WAIT;
                        cnt   <= '0;
                    end
                end
                MUL_WAIT: begin
                    if (mult_ready) begin
                        state <= IDLE;
                    end else if (!wait_done) begin
                        cnt <= sat_inc(cnt);
                    end else begin
                        state       <= IDLE;
                        mul_timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/xm_stage.sv
// Execute-to-memory boundary register: captures ALU results, resolves bne/blt,
// redirects exceptions to rstatus, and stalls upstream during multiplies.
module xm_stage
    import xm_stage_pkg::*;
#(
    parameter int MUL_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_rd,
    input  logic        in_we,
    input  logic        in_is_mul,
    input  logic        in_is_bne,
    input  logic        in_is_blt,
    input  logic [31:0] in_target,
    input  logic [31:0] ALU_out,
    input  logic [31:0] overflow,
    input  logic        ALU_exception,
    input  logic        notEqual,
    input  logic        lessThan,
    input  logic        mult_ready,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        mul_timeout
);

    logic        capture;
    logic        abort;

    logic [31:0] result_p0;
    logic [4:0]  rd_p0;
    logic        we_p0;
    logic        br_taken_p0;

    logic        vld_p1;
    logic [31:0] pc_p1;
    logic [31:0] result_p1;
    logic [4:0]  rd_p1;
    logic        we_p1;
    logic        br_taken_p1;
    logic [31:0] br_target_p1;

    mul_wait_ctrl #(
        .MUL_TIMEOUT(MUL_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_ctrl (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_is_mul  (in_is_mul),
        .mult_ready (mult_ready),
        .stall      (stall),
        .capture    (capture),
        .abort      (abort),
        .mul_timeout(mul_timeout)
    );

    // Stage p0: writeback selection; an exception wins even over rd = 0 and branches
    always_comb begin
        br_taken_p0 = (in_is_bne && notEqual) || (in_is_blt && lessThan);
        result_p0   = ALU_out;
        rd_p0       = in_rd;
        we_p0       = in_we && (in_rd != 5'd0) && !(in_is_bne || in_is_blt);
        if (ALU_exception && in_we) begin
            result_p0 = overflow;
            rd_p0     = RSTATUS_REG;
            we_p0     = 1'b1;
        end
    end

    // Stage p1: boundary register; data fields hold unless a capture occurs
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1       <= 1'b0;
            pc_p1        <= '0;
            result_p1    <= '0;
            rd_p1        <= '0;
            we_p1        <= 1'b0;
            br_taken_p1  <= 1'b0;
            br_target_p1 <= '0;
        end else begin
            vld_p1      <= capture || abort;
            we_p1       <= 1'b0;
            br_taken_p1 <= 1'b0;
            if (capture) begin
                pc_p1        <= in_pc;
                result_p1    <= result_p0;
                rd_p1        <= rd_p0;
                we_p1        <= we_p0;
                br_taken_p1  <= br_taken_p0;
                br_target_p1 <= in_target;
            end
        end
    end

    assign out_valid     = vld_p1;
    assign out_pc        = pc_p1;
    assign out_result    = result_p1;
    assign out_rd        = rd_p1;
    assign out_we        = we_p1;
    assign branch_taken  = br_taken_p1;
    assign branch_target = br_target_p1;

endmodule
